// File: rtl/aib_rst_seq_pkg.sv
// Shared types and defaults for the AIB adapter reset sequencer.
package aib_rst_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        GATE,
        DONE
    } seq_state_e;

    localparam int NUM_STG_DEF = 4;
    localparam int DLY_CYC_DEF = 16;
    localparam int TO_CYC_DEF  = 1024;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aib_rst_dly_cnt.sv
// Saturating terminal-count counter: counts 0..TC-1 while enabled, flags TC-1.
module aib_rst_dly_cnt
    import aib_rst_seq_pkg::*;
#(
    parameter int   TC = DLY_CYC_DEF,
    localparam int  W  = cnt_w(TC)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [W-1:0] TC_M1 = W'(TC - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt <= '0;
        end else if (i_en && (cnt != TC_M1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tc = (cnt == TC_M1);

endmodule

// File: rtl/aib_rst_seq_chain.sv
// In-order release of NUM_STG active-low resets with per-stage delay, readiness gate
// and rollback. Define AIB_RST_SEQ_TIMEOUT_EN to build the sticky GATE-wait timeout.
//
// state | meaning
// IDLE  | all stage resets asserted, waiting for i_start
// DELAY | counting DLY_CYC cycles for stage o_stg
// GATE  | waiting for i_stg_rdy[o_stg] to release stage o_stg
// DONE  | all stages released
module aib_rst_seq_chain
    import aib_rst_seq_pkg::*;
#(
    parameter int  NUM_STG = NUM_STG_DEF,
    parameter int  DLY_CYC = DLY_CYC_DEF,
    parameter int  TO_CYC  = TO_CYC_DEF,
    localparam int STG_W   = cnt_w(NUM_STG)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [NUM_STG-1:0] i_stg_rdy,
    output logic [NUM_STG-1:0] o_rst_n,
    output logic               o_busy,
    output logic               o_done,
    output logic [STG_W-1:0]   o_stg,
    output logic               o_timeout
);

    seq_state_e         state;
    logic               dly_tc;
    logic               to_hit;
    logic               rb_hit;
    int                 rb_idx;
    logic [NUM_STG-1:0] keep_mask;

    // Lowest released stage that lost readiness; stages below it stay released.
    always_comb begin
        rb_hit    = 1'b0;
        rb_idx    = 0;
        keep_mask = '0;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            if (o_rst_n[k] && !i_stg_rdy[k]) begin
                rb_hit = 1'b1;
                rb_idx = k;
            end
        end
        for (int k = 0; k < NUM_STG; k++) begin
            keep_mask[k] = (k < rb_idx);
        end
    end

    aib_rst_dly_cnt #(.TC(DLY_CYC)) u_dly_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr ((state != DELAY) || rb_hit || !i_start),
        .i_en  (state == DELAY),
        .o_tc  (dly_tc)
    );

`ifdef AIB_RST_SEQ_TIMEOUT_EN
    logic to_tc;

    aib_rst_dly_cnt #(.TC(TO_CYC)) u_to_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr ((state != GATE) || rb_hit || !i_start),
        .i_en  (state == GATE),
        .o_tc  (to_tc)
    );

    assign to_hit = to_tc && (state == GATE);
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_start) begin
            state     <= IDLE;
            o_rst_n   <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_stg     <= '0;
            o_timeout <= 1'b0;
        end else if (rb_hit) begin
            state   <= DELAY;
            o_rst_n <= o_rst_n & keep_mask;
            o_stg   <= STG_W'(rb_idx);
            o_busy  <= 1'b1;
            o_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state  <= DELAY;
                    o_stg  <= '0;
                    o_busy <= 1'b1;
                end
                DELAY: begin
                    if (dly_tc) begin
                        state <= GATE;
                    end
                end
                GATE: begin
                    if (to_hit) begin
                        o_timeout <= 1'b1;
                    end
                    if (i_stg_rdy[o_stg]) begin
                        o_rst_n[o_stg] <= 1'b1;
                        if (o_stg == STG_W'(NUM_STG - 1)) begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else begin
                            state <= DELAY;
                            o_stg <= o_stg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aib_rst_seq_chain.sv
// Directed vector bench for aib_rst_seq_chain (NUM_STG=4, DLY_CYC=3, TO_CYC=8).
module tb_aib_rst_seq_chain;

    localparam int NUM_STG = 4;
    localparam int DLY_CYC = 3;
    localparam int TO_CYC  = 8;
`ifdef AIB_RST_SEQ_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [NUM_STG-1:0] rdy = '1;
    logic [NUM_STG-1:0] rst_n;
    logic               busy;
    logic               done;
    logic [1:0]         stg;
    logic               timeout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aib_rst_seq_chain #(
        .NUM_STG (NUM_STG),
        .DLY_CYC (DLY_CYC),
        .TO_CYC  (TO_CYC)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_stg_rdy (rdy),
        .o_rst_n   (rst_n),
        .o_busy    (busy),
        .o_done    (done),
        .o_stg     (stg),
        .o_timeout (timeout)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic [3:0] rdy;
        int         ncyc;
        logic [3:0] e_rst_n;
        logic       e_busy;
        logic       e_done;
        logic [1:0] e_stg;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Invariants checked every cycle away from the active edge.
    always @(negedge clk) begin
        n_chk++;
        if ((rst_n & (rst_n + 4'd1)) != 4'd0) begin
            n_fail++;
            $display("FAIL thermometer: o_rst_n=%b at %0t", rst_n, $time);
        end
        n_chk++;
        if (busy && done) begin
            n_fail++;
            $display("FAIL busy_done_excl: busy=%b done=%b at %0t", busy, done, $time);
        end
    end

    vec_t vecs[$];
    int   lat;

    initial begin
        //             rst   start rdy      ncyc e_rst_n  busy  done  stg
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 2,  4'b0000, 1'b0, 1'b0, 2'd0}); // reset
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 2,  4'b0000, 1'b0, 1'b0, 2'd0}); // idle, start low
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 1,  4'b0000, 1'b1, 1'b0, 2'd0}); // E0: into DELAY
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 3,  4'b0000, 1'b1, 1'b0, 2'd0}); // E0+3 GATE
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 1,  4'b0001, 1'b1, 1'b0, 2'd1}); // E0+4
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 3,  4'b0001, 1'b1, 1'b0, 2'd1}); // E0+7
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 1,  4'b0011, 1'b1, 1'b0, 2'd2}); // E0+8
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 4,  4'b0111, 1'b1, 1'b0, 2'd3}); // E0+12
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 3,  4'b0111, 1'b1, 1'b0, 2'd3}); // E0+15
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 1,  4'b1111, 1'b0, 1'b1, 2'd3}); // E0+16 done
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 5,  4'b1111, 1'b0, 1'b1, 2'd3}); // hold DONE
        vecs.push_back('{1'b0, 1'b1, 4'b1101, 1,  4'b0001, 1'b1, 1'b0, 2'd1}); // rollback j=1
        vecs.push_back('{1'b0, 1'b1, 4'b1101, 3,  4'b0001, 1'b1, 1'b0, 2'd1}); // GATE stg1
        vecs.push_back('{1'b0, 1'b1, 4'b1101, 2,  4'b0001, 1'b1, 1'b0, 2'd1}); // waiting
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 1,  4'b0011, 1'b1, 1'b0, 2'd2}); // stg1 released
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 4,  4'b0111, 1'b1, 1'b0, 2'd3});
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 4,  4'b1111, 1'b0, 1'b1, 2'd3});
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 1,  4'b0000, 1'b0, 1'b0, 2'd0}); // abort in DONE
        vecs.push_back('{1'b0, 1'b1, 4'b1011, 9,  4'b0011, 1'b1, 1'b0, 2'd2}); // gate stage 2
        vecs.push_back('{1'b0, 1'b1, 4'b1011, 5,  4'b0011, 1'b1, 1'b0, 2'd2}); // still gated
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 1,  4'b0111, 1'b1, 1'b0, 2'd3}); // stg2 released
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 4,  4'b1111, 1'b0, 1'b1, 2'd3});
        vecs.push_back('{1'b0, 1'b1, 4'b1110, 1,  4'b0000, 1'b1, 1'b0, 2'd0}); // rollback j=0
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 4,  4'b0001, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 5,  4'b0011, 1'b1, 1'b0, 2'd2}); // mid-DELAY stg2
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 1,  4'b0000, 1'b0, 1'b0, 2'd0}); // abort
        vecs.push_back('{1'b0, 1'b1, 4'b1011, 12, 4'b0011, 1'b1, 1'b0, 2'd2}); // GATE stg2
        vecs.push_back('{1'b1, 1'b1, 4'b1011, 1,  4'b0000, 1'b0, 1'b0, 2'd0}); // rst mid-GATE
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 1,  4'b0000, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 8,  4'b0011, 1'b1, 1'b0, 2'd2});
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 2,  4'b0011, 1'b1, 1'b0, 2'd2}); // DELAY stg2
        vecs.push_back('{1'b0, 1'b1, 4'b1101, 1,  4'b0001, 1'b1, 1'b0, 2'd1}); // rollback in DELAY
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 1,  4'b0000, 1'b0, 1'b0, 2'd0});

        #1;
        foreach (vecs[i]) begin
            rst   = vecs[i].rst;
            start = vecs[i].start;
            rdy   = vecs[i].rdy;
            tick(vecs[i].ncyc);
            check($sformatf("v%0d rst_n", i), int'(rst_n), int'(vecs[i].e_rst_n));
            check($sformatf("v%0d busy", i), int'(busy), int'(vecs[i].e_busy));
            check($sformatf("v%0d done", i), int'(done), int'(vecs[i].e_done));
            check($sformatf("v%0d stg", i), int'(stg), int'(vecs[i].e_stg));
            check($sformatf("v%0d timeout", i), int'(timeout), 0);
        end

        // Release latency: start sampled at edge E0, last stage released at E0+NUM_STG*(DLY_CYC+1).
        rst = 1'b0; start = 1'b0; rdy = '1;
        tick(1);
        start = 1'b1;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            lat++;
            if (done) break;
        end
        check("done_latency", lat, 1 + NUM_STG * (DLY_CYC + 1));
        check("done_latency_rst_n", int'(rst_n), 15);

        // Readiness timeout on stage 0.
        start = 1'b0;
        tick(1);
        start = 1'b1; rdy = 4'b0000;
        tick(1);                       // E0
        tick(10);                      // E0+10: seven GATE cycles
        check("to_before", int'(timeout), 0);
        tick(1);                       // E0+11: eighth GATE cycle
        check("to_reached", int'(timeout), int'(TO_EN));
        check("to_still_waiting", int'(busy), 1);
        rdy = 4'b1111;
        tick(1);
        check("to_release_rst_n", int'(rst_n), 1);
        check("to_sticky", int'(timeout), int'(TO_EN));
        start = 1'b0;
        tick(1);
        check("to_cleared", int'(timeout), 0);

        // Random start/readiness to exercise the invariant monitor.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 19) != 0);
            for (int b = 0; b < NUM_STG; b++) rdy[b] = ($urandom_range(0, 9) != 0);
            tick(1);
        end
        start = 1'b0;
        tick(1);
        check("final_idle_rst_n", int'(rst_n), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
